// File: rtl/core_cache_ctrl.sv
// core_cache_ctrl: direct-mapped, write-through, no-write-allocate L1.
// Hits answer in one cycle; read misses refill a whole line from memory.
module core_cache_ctrl #(
  parameter int INDEX_AW   = 8,
  parameter int OFFSET_AW  = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_req_i,
  input  logic                  cache_op_i,
  input  logic [INDEX_AW-1:0]   cache_index_i,
  input  logic [TAG_WIDTH-1:0]  cache_tag_i,
  input  logic [OFFSET_AW-1:0]  cache_offset_i,
  input  logic [RAM_NUM-1:0]    cache_wr_en_i,
  input  logic [DATA_WIDTH-1:0] cache_wr_data_i,
  output logic [DATA_WIDTH-1:0] cache_rd_data_o,
  output logic                  cache_addr_ack_o,
  output logic                  cache_data_ack_o,
  output logic                  mem_rd_req_o,
  output logic [31:0]           mem_rd_addr_o,
  input  logic                  mem_rd_ack_i,
  input  logic                  mem_rd_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  mem_wr_req_o,
  output logic [31:0]           mem_wr_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [RAM_NUM-1:0]    mem_wr_strb_o,
  input  logic                  mem_wr_ack_i
);

  localparam int LINES = 1 << INDEX_AW;
  localparam int WSEL  = OFFSET_AW - 2;
  localparam int WPL   = 1 << WSEL;
  localparam int BW    = DATA_WIDTH / RAM_NUM;
  localparam int DAW   = INDEX_AW + WSEL;

  localparam logic [WSEL-1:0] W_ONE  = 1;
  localparam logic [WSEL-1:0] W_LAST = WPL - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state_q;

  logic                  op_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [INDEX_AW-1:0]   idx_q;
  logic [OFFSET_AW-1:0]  off_q;
  logic [RAM_NUM-1:0]    strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WSEL-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] crit_q;

  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_arr [LINES];
  logic [DATA_WIDTH-1:0] data_arr [LINES*WPL];

  logic [WSEL-1:0]       wsel;
  logic [DAW-1:0]        hit_addr;
  logic [DAW-1:0]        fill_addr;
  logic [DATA_WIDTH-1:0] hit_word;
  logic                  hit;
  logic                  rd_hit;
  logic                  wr_hit;
  logic                  fill_beat;
  logic                  fill_last;
  logic                  accept;

  assign wsel      = off_q[OFFSET_AW-1:2];
  assign hit_addr  = {idx_q, wsel};
  assign fill_addr = {idx_q, cnt_q};
  assign hit_word  = data_arr[hit_addr];
  assign hit       = valid_q[idx_q] && (tag_arr[idx_q] == tag_q);
  assign rd_hit    = (state_q == S_LOOKUP) && !op_q && hit;
  assign wr_hit    = (state_q == S_LOOKUP) && op_q && hit;
  assign fill_beat = (state_q == S_REFILL) && mem_rd_valid_i;
  assign fill_last = fill_beat && (cnt_q == W_LAST);
  assign accept    = cache_req_i && ((state_q == S_IDLE) || rd_hit);

  // Handshake pulses and read data decoded from registered state
  always_comb begin
    cache_addr_ack_o = accept;
    cache_data_ack_o = rd_hit || (state_q == S_RESP);
    cache_rd_data_o  = '0;
    if (rd_hit)
      cache_rd_data_o = hit_word;
    else if ((state_q == S_RESP) && !op_q)
      cache_rd_data_o = crit_q;
  end

  // Line valid bits: set on the last refill beat, wiped by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid_q <= '0;
    else if (fill_last)
      valid_q[idx_q] <= 1'b1;
  end

  // Tag and data storage: refill beats and write-hit byte merges
  always_ff @(posedge clk) begin
    if (fill_beat)
      data_arr[fill_addr] <= mem_rd_data_i;
    if (fill_last)
      tag_arr[idx_q] <= tag_q;
    if (wr_hit)
      for (int b = 0; b < RAM_NUM; b++)
        if (strb_q[b])
          data_arr[hit_addr][b*BW +: BW] <= wdata_q[b*BW +: BW];
  end

  // Control FSM with registered memory-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= 1'b0;
      tag_q         <= '0;
      idx_q         <= '0;
      off_q         <= '0;
      strb_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      crit_q        <= '0;
      mem_rd_req_o  <= 1'b0;
      mem_rd_addr_o <= '0;
      mem_wr_req_o  <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      mem_wr_strb_o <= '0;
    end else begin
      if (accept) begin
        op_q    <= cache_op_i;
        tag_q   <= cache_tag_i;
        idx_q   <= cache_index_i;
        off_q   <= cache_offset_i;
        strb_q  <= cache_wr_en_i;
        wdata_q <= cache_wr_data_i;
      end
      unique case (state_q)
        S_IDLE: begin
          if (cache_req_i)
            state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (op_q) begin
            mem_wr_req_o  <= 1'b1;
            mem_wr_addr_o <= {tag_q, idx_q, wsel, 2'b00};
            mem_wr_data_o <= wdata_q;
            mem_wr_strb_o <= strb_q;
            state_q       <= S_WRITE;
          end else if (hit) begin
            state_q <= cache_req_i ? S_LOOKUP : S_IDLE;
          end else begin
            mem_rd_req_o  <= 1'b1;
            mem_rd_addr_o <= {tag_q, idx_q, {OFFSET_AW{1'b0}}};
            state_q       <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          if (mem_rd_ack_i) begin
            mem_rd_req_o <= 1'b0;
            cnt_q        <= '0;
            state_q      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_rd_valid_i) begin
            cnt_q <= cnt_q + W_ONE;
            if (cnt_q == wsel)
              crit_q <= mem_rd_data_i;
            if (cnt_q == W_LAST)
              state_q <= S_RESP;
          end
        end
        S_WRITE: begin
          if (mem_wr_ack_i) begin
            mem_wr_req_o <= 1'b0;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_cache_ctrl.sv
// tb_core_cache_ctrl: directed bench with a completion scoreboard.
// Memory side is driven by hand so gaps and resets land on exact cycles.
module tb_core_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_req;
  logic        cache_op;
  logic [7:0]  cache_index;
  logic [19:0] cache_tag;
  logic [3:0]  cache_offset;
  logic [3:0]  cache_wr_en;
  logic [31:0] cache_wr_data;
  logic [31:0] cache_rd_data;
  logic        addr_ack;
  logic        data_ack;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_q;

  core_cache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cache_req_i      (cache_req),
    .cache_op_i       (cache_op),
    .cache_index_i    (cache_index),
    .cache_tag_i      (cache_tag),
    .cache_offset_i   (cache_offset),
    .cache_wr_en_i    (cache_wr_en),
    .cache_wr_data_i  (cache_wr_data),
    .cache_rd_data_o  (cache_rd_data),
    .cache_addr_ack_o (addr_ack),
    .cache_data_ack_o (data_ack),
    .mem_rd_req_o     (mem_rd_req),
    .mem_rd_addr_o    (mem_rd_addr),
    .mem_rd_ack_i     (mem_rd_ack),
    .mem_rd_valid_i   (mem_rd_valid),
    .mem_rd_data_i    (mem_rd_data),
    .mem_wr_req_o     (mem_wr_req),
    .mem_wr_addr_o    (mem_wr_addr),
    .mem_wr_data_o    (mem_wr_data),
    .mem_wr_strb_o    (mem_wr_strb),
    .mem_wr_ack_i     (mem_wr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every completion pops the oldest expected read data
  always @(negedge clk) begin
    if (!rst && data_ack) begin
      if (sb.size() == 0) begin
        chk("spurious_data_ack", {31'b0, data_ack}, 32'd0);
      end else begin
        exp_q = sb.pop_front();
        chk("rd_data", cache_rd_data, exp_q);
      end
    end
  end

  task automatic wait_out(input int which, input string tag);
    logic s;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      s = (which == 0) ? addr_ack :
          (which == 1) ? mem_rd_req : mem_wr_req;
      if (s) break;
      n++;
      if (n > 40) begin
        chk(tag, {31'b0, s}, 32'd1);
        break;
      end
    end
  endtask

  task automatic drive_req(input logic op, input logic [31:0] a,
                           input logic [3:0] strb, input logic [31:0] d);
    cache_op      = op;
    cache_tag     = a[31:12];
    cache_index   = a[11:4];
    cache_offset  = a[3:0];
    cache_wr_en   = strb;
    cache_wr_data = d;
    cache_req     = 1'b1;
    wait_out(0, "accept_timeout");
    @(posedge clk);
    #1;
    cache_req = 1'b0;
  endtask

  task automatic refill(input logic [31:0] a, input logic [31:0] base,
                        input int gap_at);
    wait_out(1, "rd_req_timeout");
    chk("mem_rd_addr", mem_rd_addr, a);
    mem_rd_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_rd_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        mem_rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      mem_rd_valid = 1'b1;
      mem_rd_data  = base + 32'(i);
      @(posedge clk);
      #1;
    end
    mem_rd_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic write_thru(input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
    wait_out(2, "wr_req_timeout");
    chk("mem_wr_addr", mem_wr_addr, a);
    chk("mem_wr_strb", {28'b0, mem_wr_strb}, {28'b0, s});
    chk("mem_wr_data", mem_wr_data, d);
    mem_wr_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_wr_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [31:0] e);
    sb.push_back(e);
    drive_req(1'b0, a, 4'h0, 32'h0);
    @(negedge clk);
    chk("hit_data_ack", {31'b0, data_ack}, 32'd1);
    chk("hit_no_rd_req", {31'b0, mem_rd_req}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_rd_data"}, cache_rd_data, 32'h0);
    chk({tag, "_acks"}, {30'b0, addr_ack, data_ack}, 32'h0);
    chk({tag, "_rd_req"}, {31'b0, mem_rd_req}, 32'h0);
    chk({tag, "_rd_addr"}, mem_rd_addr, 32'h0);
    chk({tag, "_wr_req"}, {31'b0, mem_wr_req}, 32'h0);
    chk({tag, "_wr_addr"}, mem_wr_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    cache_req = 1'b0;
    cache_op = 1'b0;
    cache_index = '0;
    cache_tag = '0;
    cache_offset = '0;
    cache_wr_en = '0;
    cache_wr_data = '0;
    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    mem_wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    outs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    sb.push_back(32'hA0);
    drive_req(1'b0, 32'h0001_2340, 4'h0, 32'h0);
    refill(32'h0001_2340, 32'hA0, 4);

    read_hit(32'h0001_2348, 32'hA2);

    for (int i = 0; i < 8; i++) begin
      cache_op     = 1'b0;
      cache_tag    = 20'h00012;
      cache_index  = 8'h34;
      cache_offset = 4'(4 * (i % 4));
      cache_req    = 1'b1;
      sb.push_back(32'hA0 + 32'(i % 4));
      @(negedge clk);
      chk("b2b_addr_ack", {31'b0, addr_ack}, 32'd1);
      if (i > 0)
        chk("b2b_data_ack", {31'b0, data_ack}, 32'd1);
      @(posedge clk);
      #1;
    end
    cache_req = 1'b0;
    @(negedge clk);
    chk("b2b_last_ack", {31'b0, data_ack}, 32'd1);
    @(posedge clk);
    #1;

    sb.push_back(32'h0);
    drive_req(1'b1, 32'h0001_2344, 4'b0011, 32'hDEAD_BEEF);
    write_thru(32'h0001_2344, 4'b0011, 32'hDEAD_BEEF);
    read_hit(32'h0001_2344, 32'h0000_BEEF);

    sb.push_back(32'h0);
    drive_req(1'b1, 32'h0005_0000, 4'hF, 32'h1234_5678);
    write_thru(32'h0005_0000, 4'hF, 32'h1234_5678);
    sb.push_back(32'hB0);
    drive_req(1'b0, 32'h0005_0000, 4'h0, 32'h0);
    refill(32'h0005_0000, 32'hB0, 4);

    sb.push_back(32'hC2);
    drive_req(1'b0, 32'h0006_0008, 4'h0, 32'h0);
    refill(32'h0006_0000, 32'hC0, 2);
    read_hit(32'h0006_000C, 32'hC3);

    drive_req(1'b0, 32'h0007_0004, 4'h0, 32'h0);
    wait_out(1, "rd_req2_timeout");
    mem_rd_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hE0;
    @(posedge clk);
    #1;
    mem_rd_data = 32'hE1;
    rst = 1'b1;
    @(negedge clk);
    outs_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rd_data = 32'hE2 + 32'(i);
      @(negedge clk);
      chk("stray_data_ack", {31'b0, data_ack}, 32'd0);
      chk("stray_rd_req", {31'b0, mem_rd_req}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_rd_valid = 1'b0;

    sb.push_back(32'hD0);
    drive_req(1'b0, 32'h0001_2340, 4'h0, 32'h0);
    refill(32'h0001_2340, 32'hD0, 4);
    sb.push_back(32'hF2);
    drive_req(1'b0, 32'h0006_0008, 4'h0, 32'h0);
    refill(32'h0006_0000, 32'hF0, 4);

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
